// File: rtl/m_dram_arbiter_if.sv
// Bus bundles for the DRAM arbiter: the per-hart requester side and the
// single downstream controller port.
interface m_dram_req_if #(
  parameter int NPORT = 2
);
  logic [32*NPORT-1:0] w_req_addr;
  logic [32*NPORT-1:0] w_req_wdata;
  logic [3*NPORT-1:0]  w_req_ctrl;
  logic [NPORT-1:0]    w_req_we;
  logic [NPORT-1:0]    w_req_le;
  logic [32*NPORT-1:0] w_req_odata;
  logic [NPORT-1:0]    w_req_busy;

  modport master (
    output w_req_addr, w_req_wdata, w_req_ctrl, w_req_we, w_req_le,
    input  w_req_odata, w_req_busy
  );
  modport slave (
    input  w_req_addr, w_req_wdata, w_req_ctrl, w_req_we, w_req_le,
    output w_req_odata, w_req_busy
  );
endinterface

interface m_dram_mem_if;
  logic [31:0] w_dram_addr;
  logic [31:0] w_dram_wdata;
  logic [2:0]  w_dram_ctrl;
  logic        w_dram_we_t;
  logic        w_dram_le;
  logic [31:0] w_dram_odata;
  logic        w_dram_busy;

  modport master (
    output w_dram_addr, w_dram_wdata, w_dram_ctrl, w_dram_we_t, w_dram_le,
    input  w_dram_odata, w_dram_busy
  );
  modport slave (
    input  w_dram_addr, w_dram_wdata, w_dram_ctrl, w_dram_we_t, w_dram_le,
    output w_dram_odata, w_dram_busy
  );
endinterface

// File: rtl/m_dram_arbiter.sv
// Round-robin arbiter sharing one DRAM controller port between NPORT harts;
// one latched request per hart, one downstream transaction at a time.
module m_dram_arbiter #(
  parameter int NPORT = 2,
  parameter int PW    = 3
) (
  input  logic          CLK,
  input  logic          RST_X,
  m_dram_req_if.slave   req,
  m_dram_mem_if.master  dram,
  output logic [PW-1:0] w_grant,
  output logic          w_proto_err
);
  localparam int DATA_W = 32;
  localparam int CTRL_W = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [NPORT-1:0]  pending;
  logic [PW-1:0]     last_grant;
  logic [PW-1:0]     grant;
  logic              proto_err;

  logic [DATA_W-1:0] lat_addr  [NPORT];
  logic [DATA_W-1:0] lat_wdata [NPORT];
  logic [CTRL_W-1:0] lat_ctrl  [NPORT];
  logic [NPORT-1:0]  lat_store;
  logic [DATA_W-1:0] odata     [NPORT];

  logic [NPORT-1:0]  pulse;
  logic [NPORT-1:0]  accept;
  logic [NPORT-1:0]  collide;
  logic [NPORT-1:0]  grant_oh;
  logic [PW-1:0]     pick;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [CTRL_W-1:0] sel_ctrl;
  logic              sel_store;

  // Walk the ports starting just after the last winner, wrapping at NPORT.
  function automatic logic [PW-1:0] rr_pick(input logic [NPORT-1:0] pend,
                                            input logic [PW-1:0]    last);
    logic [PW-1:0] idx;
    logic          found;
    logic          hit;
    rr_pick = last;
    found   = 1'b0;
    idx     = last;
    for (int k = 0; k < NPORT; k++) begin
      idx = (idx == PW'(NPORT-1)) ? '0 : idx + PW'(1);
      hit = 1'b0;
      for (int j = 0; j < NPORT; j++) begin
        if (idx == PW'(j)) hit = pend[j];
      end
      if (!found && hit) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    pulse          = req.w_req_we | req.w_req_le;
    accept         = pulse & ~pending;
    collide        = (pulse & pending) | (req.w_req_we & req.w_req_le);
    req.w_req_busy = pending | pulse;
    pick           = rr_pick(pending, last_grant);
    grant_oh       = '0;
    sel_addr       = '0;
    sel_wdata      = '0;
    sel_ctrl       = '0;
    sel_store      = 1'b0;
    req.w_req_odata = '0;
    for (int i = 0; i < NPORT; i++) begin
      grant_oh[i] = (grant == PW'(i));
      if (grant_oh[i]) begin
        sel_addr  = lat_addr[i];
        sel_wdata = lat_wdata[i];
        sel_ctrl  = lat_ctrl[i];
        sel_store = lat_store[i];
      end
      req.w_req_odata[i*DATA_W +: DATA_W] = odata[i];
    end
  end

  // Downstream bus is quiet while idle and holds the granted latch otherwise.
  always_comb begin
    dram.w_dram_addr  = '0;
    dram.w_dram_wdata = '0;
    dram.w_dram_ctrl  = '0;
    dram.w_dram_we_t  = 1'b0;
    dram.w_dram_le    = 1'b0;
    if (state != S_IDLE) begin
      dram.w_dram_addr  = sel_addr;
      dram.w_dram_wdata = sel_wdata;
      dram.w_dram_ctrl  = sel_ctrl;
    end
    if (state == S_ISSUE) begin
      dram.w_dram_we_t = sel_store;
      dram.w_dram_le   = ~sel_store;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state      <= S_IDLE;
      pending    <= '0;
      last_grant <= PW'(NPORT-1);
      grant      <= '0;
      proto_err  <= 1'b0;
    end else begin
      pending <= (pending & ~((state == S_DONE) ? grant_oh : '0)) | accept;
      if (|collide) proto_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (|pending) begin
            grant      <= pick;
            last_grant <= pick;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  if (!dram.w_dram_busy) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      for (int i = 0; i < NPORT; i++) odata[i] <= '0;
    end else if (state == S_DONE && !sel_store) begin
      for (int i = 0; i < NPORT; i++) begin
        if (grant_oh[i]) odata[i] <= dram.w_dram_odata;
      end
    end
  end

  // Request fields are captured only on an accepted pulse; store wins a we/le tie.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NPORT; i++) begin
      if (accept[i]) begin
        lat_addr[i]  <= req.w_req_addr[i*DATA_W +: DATA_W];
        lat_wdata[i] <= req.w_req_wdata[i*DATA_W +: DATA_W];
        lat_ctrl[i]  <= req.w_req_ctrl[i*CTRL_W +: CTRL_W];
        lat_store[i] <= req.w_req_we[i];
      end
    end
  end

  assign w_grant     = grant;
  assign w_proto_err = proto_err;
endmodule

// File: tb/tb_m_dram_arbiter.sv
// Self-checking bench for m_dram_arbiter: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_m_dram_arbiter;
  localparam int NP = 2;
  localparam int PW = 3;

  logic CLK = 1'b0;
  logic RST_X;
  always #5 CLK = ~CLK;

  m_dram_req_if #(.NPORT(NP)) rq();
  m_dram_mem_if mm();
  logic [PW-1:0] w_grant;
  logic          w_proto_err;

  m_dram_arbiter #(.NPORT(NP), .PW(PW)) dut (
    .CLK(CLK), .RST_X(RST_X), .req(rq), .dram(mm),
    .w_grant(w_grant), .w_proto_err(w_proto_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Controller stand-in: busy for ctl_lat cycles after each pulse.
  int          ctl_lat = 4;
  int          ctl_cnt = 0;
  logic [31:0] ctl_rdata = '0;
  always @(posedge CLK) begin
    if (!RST_X) ctl_cnt <= 0;
    else if (mm.w_dram_we_t || mm.w_dram_le) ctl_cnt <= ctl_lat;
    else if (ctl_cnt > 0) ctl_cnt <= ctl_cnt - 1;
  end
  assign mm.w_dram_busy  = (ctl_cnt != 0);
  assign mm.w_dram_odata = ctl_rdata;

  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  bit          log_store[$];
  int          log_grant[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: pending/latch per port, an owner and the cycle
  // stamps of its issue and completion.
  bit          armed = 1'b0;
  bit          m_pend[NP];
  logic [31:0] m_addr[NP];
  logic [31:0] m_wdata[NP];
  logic [2:0]  m_ctrl[NP];
  bit          m_store[NP];
  logic [31:0] m_odata[NP];
  bit          m_err;
  int          m_last, m_grant, m_owner, m_issue, m_done;

  initial begin
    forever begin
      @(negedge CLK);
      if (armed) begin
        bit ex_we, ex_le;
        ex_we = (m_owner >= 0) && (cyc == m_issue) && m_store[m_owner];
        ex_le = (m_owner >= 0) && (cyc == m_issue) && !m_store[m_owner];
        for (int i = 0; i < NP; i++) begin
          chk("busy", 32'(rq.w_req_busy[i]), 32'(m_pend[i] | rq.w_req_we[i] | rq.w_req_le[i]));
          chk("odata", rq.w_req_odata[i*32 +: 32], m_odata[i]);
        end
        chk("dram_we_t", 32'(mm.w_dram_we_t), 32'(ex_we));
        chk("dram_le", 32'(mm.w_dram_le), 32'(ex_le));
        chk("dram_addr", mm.w_dram_addr, (m_owner >= 0) ? m_addr[m_owner] : 32'h0);
        chk("dram_wdata", mm.w_dram_wdata, (m_owner >= 0) ? m_wdata[m_owner] : 32'h0);
        chk("dram_ctrl", 32'(mm.w_dram_ctrl), (m_owner >= 0) ? 32'(m_ctrl[m_owner]) : 32'h0);
        chk("grant", 32'(w_grant), 32'(m_grant));
        chk("proto_err", 32'(w_proto_err), 32'(m_err));
        chk("no_overlap", 32'((mm.w_dram_we_t || mm.w_dram_le) && mm.w_dram_busy), 32'h0);
        if (mm.w_dram_we_t === 1'b1 || mm.w_dram_le === 1'b1) begin
          log_addr.push_back(mm.w_dram_addr);
          log_wdata.push_back(mm.w_dram_wdata);
          log_store.push_back(mm.w_dram_we_t);
          log_grant.push_back(int'(w_grant));
        end
      end
      if (RST_X === 1'b0) begin
        armed = 1'b1;
        for (int i = 0; i < NP; i++) begin
          m_pend[i] = 1'b0;
          m_odata[i] = '0;
        end
        m_err = 1'b0; m_last = NP - 1; m_grant = 0; m_owner = -1; m_issue = -1; m_done = -1;
      end else if (armed) begin
        bit old_pend[NP];
        bit found;
        int ow;
        ow = m_owner;
        old_pend = m_pend;
        if (m_owner < 0) begin
          found = 1'b0;
          for (int k = 1; k <= NP; k++) begin
            int idx;
            idx = (m_last + k) % NP;
            if (!found && old_pend[idx]) begin
              found = 1'b1; m_owner = idx; m_last = idx; m_grant = idx;
              m_issue = cyc + 1; m_done = -1;
            end
          end
        end else if (m_done < 0) begin
          if (cyc > m_issue && !mm.w_dram_busy) m_done = cyc + 1;
        end else if (cyc == m_done) begin
          if (!m_store[ow]) m_odata[ow] = mm.w_dram_odata;
          m_pend[ow] = 1'b0;
          m_owner = -1;
        end
        for (int i = 0; i < NP; i++) begin
          if (rq.w_req_we[i] || rq.w_req_le[i]) begin
            if (old_pend[i] || (rq.w_req_we[i] && rq.w_req_le[i])) m_err = 1'b1;
            if (!old_pend[i]) begin
              m_pend[i]  = 1'b1;
              m_addr[i]  = rq.w_req_addr[i*32 +: 32];
              m_wdata[i] = rq.w_req_wdata[i*32 +: 32];
              m_ctrl[i]  = rq.w_req_ctrl[i*3 +: 3];
              m_store[i] = rq.w_req_we[i];
            end
          end
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    RST_X = 1'b0;
    repeat (n) tick();
    RST_X = 1'b1;
  endtask

  task automatic set_req(input int p, input bit st, input bit ld,
                         input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    rq.w_req_addr[p*32 +: 32]  = a;
    rq.w_req_wdata[p*32 +: 32] = d;
    rq.w_req_ctrl[p*3 +: 3]    = c;
    rq.w_req_we[p] = st;
    rq.w_req_le[p] = ld;
  endtask

  task automatic clear_pulses();
    rq.w_req_we = '0;
    rq.w_req_le = '0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n;
    n = 0;
    while (rq.w_req_busy !== '0 && n < max) begin
      tick();
      n++;
    end
    chk(name, 32'(n < max), 32'h1);
  endtask

  initial begin
    int base, n, issued;
    RST_X = 1'b0;
    rq.w_req_addr = '0; rq.w_req_wdata = '0; rq.w_req_ctrl = '0;
    clear_pulses();

    // Reset state, then a single uncontended load.
    do_reset(2);
    chk("rst_grant", 32'(w_grant), 32'h0);
    chk("rst_err", 32'(w_proto_err), 32'h0);
    chk("rst_odata", rq.w_req_odata[31:0] | rq.w_req_odata[63:32], 32'h0);
    chk("rst_le", 32'(mm.w_dram_le | mm.w_dram_we_t), 32'h0);
    chk("rst_busy", 32'(rq.w_req_busy), 32'h0);
    ctl_lat = 4; ctl_rdata = 32'hDEADBEEF;
    base = log_addr.size();
    set_req(0, 1'b0, 1'b1, 32'h80001000, 32'h0, 3'b010);
    n = 0;
    do begin
      n++;
      tick();
      clear_pulses();
    end while (rq.w_req_busy[0] === 1'b1 && n < 50);
    chk("load_busy_len", n, 32'd9);
    chk("load_count", log_addr.size() - base, 32'd1);
    chk("load_addr", log_addr[base], 32'h80001000);
    chk("load_is_load", 32'(log_store[base]), 32'h0);
    chk("load_odata0", rq.w_req_odata[31:0], 32'hDEADBEEF);

    // Simultaneous store on port 0 and load on port 1 after reset.
    do_reset(1);
    ctl_rdata = 32'h22220200;
    base = log_addr.size();
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h11, 3'b010);
    set_req(1, 1'b0, 1'b1, 32'h200, 32'h0, 3'b010);
    tick(); clear_pulses();
    wait_idle(100, "simul_timeout");
    chk("simul_count", log_addr.size() - base, 32'd2);
    chk("simul_grant0", log_grant[base], 32'd0);
    chk("simul_grant1", log_grant[base+1], 32'd1);
    chk("simul_st_addr", log_addr[base], 32'h100);
    chk("simul_st_data", log_wdata[base], 32'h11);
    chk("simul_st_kind", 32'(log_store[base]), 32'h1);
    chk("simul_ld_addr", log_addr[base+1], 32'h200);
    chk("simul_odata1", rq.w_req_odata[63:32], 32'h22220200);
    chk("simul_odata0", rq.w_req_odata[31:0], 32'h0);

    // Round robin with both ports re-requesting as soon as they are free.
    ctl_lat = 2; ctl_rdata = 32'h00000C0C;
    base = log_addr.size();
    issued = 0; n = 0;
    while (log_addr.size() - base < 10 && n < 400) begin
      for (int p = 0; p < NP; p++) begin
        if (rq.w_req_busy[p] === 1'b0 && issued < 10) begin
          set_req(p, 1'b0, 1'b1, 32'h1000 + 32'(issued * 16 + p * 4), 32'h0, 3'b000);
          issued++;
        end
      end
      tick(); clear_pulses(); #1;
      n++;
    end
    wait_idle(100, "rr_timeout");
    chk("rr_count", log_addr.size() - base, 32'd10);
    for (int k = 0; k < 10 && base + k < log_grant.size(); k++)
      chk("rr_grant", log_grant[base+k], 32'(k % 2));

    // Second load on port 1 while pending is ignored and flagged.
    ctl_lat = 5; ctl_rdata = 32'h00003333;
    base = log_addr.size();
    tick();
    set_req(1, 1'b0, 1'b1, 32'h300, 32'h0, 3'b001);
    tick(); clear_pulses(); tick();
    set_req(1, 1'b0, 1'b1, 32'h400, 32'h0, 3'b001);
    tick(); clear_pulses();
    chk("perr_set", 32'(w_proto_err), 32'h1);
    wait_idle(100, "perr_timeout");
    chk("perr_count", log_addr.size() - base, 32'd1);
    chk("perr_addr", log_addr[base], 32'h300);
    chk("perr_sticky", 32'(w_proto_err), 32'h1);

    // Store on port 1 leaves both odata words alone.
    ctl_rdata = 32'h5;
    set_req(1, 1'b0, 1'b1, 32'h500, 32'h0, 3'b010);
    tick(); clear_pulses();
    wait_idle(100, "iso_ld_timeout");
    chk("iso_odata1_load", rq.w_req_odata[63:32], 32'h5);
    ctl_rdata = 32'h99;
    base = log_addr.size();
    set_req(1, 1'b1, 1'b0, 32'h504, 32'hABCD, 3'b010);
    tick(); clear_pulses();
    wait_idle(100, "iso_st_timeout");
    chk("iso_st_kind", 32'(log_store[base]), 32'h1);
    chk("iso_st_data", log_wdata[base], 32'hABCD);
    chk("iso_odata1_kept", rq.w_req_odata[63:32], 32'h5);
    chk("iso_odata0_kept", rq.w_req_odata[31:0], 32'h00000C0C);

    // Reset while port 1 is in its WAIT phase.
    ctl_lat = 8; ctl_rdata = 32'h66;
    set_req(1, 1'b0, 1'b1, 32'h600, 32'h0, 3'b010);
    tick(); clear_pulses();
    repeat (3) tick();
    do_reset(1);
    chk("mid_busy", 32'(rq.w_req_busy), 32'h0);
    chk("mid_odata", rq.w_req_odata[31:0] | rq.w_req_odata[63:32], 32'h0);
    chk("mid_err", 32'(w_proto_err), 32'h0);
    base = log_addr.size();
    repeat (3) tick();
    chk("mid_no_pulse", log_addr.size() - base, 32'd0);
    ctl_lat = 3; ctl_rdata = 32'h77;
    set_req(1, 1'b0, 1'b1, 32'h700, 32'h0, 3'b010);
    tick(); clear_pulses();
    wait_idle(100, "mid_timeout");
    chk("mid_new_count", log_addr.size() - base, 32'd1);
    chk("mid_new_addr", log_addr[base], 32'h700);
    chk("mid_new_grant", log_grant[base], 32'd1);
    chk("mid_new_odata", rq.w_req_odata[63:32], 32'h77);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/m_dram_arbiter.md
Name: m_dram_arbiter

Overview:
- Shares the single DRAM controller port between NPORT harts. Each hart's MMU DRAM interface (addr/wdata/we_t/le/ctrl out; odata/busy in) connects to one requester slot.
- Latches one outstanding request per hart and grants the DRAM round-robin. Issues exactly one transaction at a time downstream and routes read data and busy back to the owner.
- Sits between the per-hart MMU instances and the DRAM controller in the multi-hart top.

Parameters:
- NPORT, 2, number of requesting harts (2..8).
- PW, 3, width of the grant index; must satisfy 2**PW >= NPORT.

Ports:
- CLK  in  1  system clock.
- RST_X  in  1  reset; synchronous, active-low.
- w_req_addr  in  32*NPORT  per-port DRAM address; slot i is bits [32i+31:32i].
- w_req_wdata  in  32*NPORT  per-port store data.
- w_req_ctrl  in  3*NPORT  per-port access size/sign control, passed through unchanged.
- w_req_we  in  NPORT  per-port store pulse (one cycle).
- w_req_le  in  NPORT  per-port load pulse (one cycle).
- w_req_odata  out  32*NPORT  per-port returned load data.
- w_req_busy  out  NPORT  per-port busy.
- w_dram_addr  out  32  to controller.
- w_dram_wdata  out  32  to controller.
- w_dram_ctrl  out  3  to controller.
- w_dram_we_t  out  1  store pulse to controller.
- w_dram_le  out  1  load pulse to controller.
- w_dram_odata  in  32  controller read data.
- w_dram_busy  in  1  controller busy.
- w_grant  out  PW  index of the port currently or last served (debug).
- w_proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Request capture, port i:
  - A pulse on w_req_we[i] or w_req_le[i] while pending[i]==0 sets pending[i].
  - The same edge latches addr, wdata, ctrl and is_store = we.
  - If we and le are asserted together, the store wins and w_proto_err is set.
- w_req_busy[i] = pending[i] | w_req_we[i] | w_req_le[i] (combinational). Busy is therefore high in the pulse cycle itself.
- A pulse on port i while pending[i]==1 is ignored: latched fields are unchanged and w_proto_err is set. w_proto_err clears only on reset.
- FSM states:
  - IDLE: if any pending bit is set, select the grant and go to ISSUE.
    - Round-robin search starts at (last_grant+1) mod NPORT; the first pending port wins.
    - last_grant is updated to the selected port.
    - A request captured in the same cycle is not visible until the next cycle.
  - ISSUE (1 cycle):
    - Drive w_dram_addr, wdata and ctrl from the granted latch.
    - Drive w_dram_we_t = is_store and w_dram_le = !is_store for exactly this cycle.
    - Go to WAIT.
  - WAIT: the controller guarantees busy is high on the cycle after a pulse. When w_dram_busy==0, go to DONE.
  - DONE (1 cycle):
    - For loads, copy w_dram_odata into odata[grant]; stores leave odata untouched.
    - Clear pending[grant]; the port's busy drops on the next cycle.
    - Go to IDLE.
- Latency: an uncontended load with controller busy for B cycles takes pulse(t0), IDLE(t1), ISSUE(t2), WAIT(t3..t3+B), DONE, then busy low.
- w_dram_addr, wdata and ctrl hold the granted values from ISSUE through DONE. In IDLE they are 0.
- w_req_odata[i] holds its value until the next load completes for port i.
- Fairness: with all ports continuously pending, each port is served once per NPORT transactions.
- Reset (RST_X==0 at a clock edge), including mid-transaction:
  - State goes to IDLE and all pending bits clear.
  - last_grant = NPORT-1, so port 0 has first priority.
  - w_grant = 0, all odata = 0, w_proto_err = 0.
  - w_dram_we_t and w_dram_le = 0.
  - w_req_busy follows its equation; it is 0 unless a pulse is present.
  - The partly completed downstream transaction is abandoned and its data is discarded.

Test Plan:
- Reset then a single load:
  - Stimulus: w_req_le[0] pulse, addr 0x80001000; controller busy 4 cycles, returns 0xDEADBEEF.
  - Required: exactly one w_dram_le pulse with addr 0x80001000; odata[0]=0xDEADBEEF; busy[0] high from the pulse cycle until one cycle after DONE.
- Simultaneous requests:
  - Stimulus: port0 store 0x11 to 0x100 and port1 load from 0x200 in the same cycle.
  - Required: port0 is served first (after reset), then port1; the two downstream pulses never overlap; w_grant sequence is 0 then 1.
- Round-robin fairness:
  - Stimulus: NPORT=2, both ports re-request immediately after each completion, 10 transactions.
  - Required: grants alternate 0,1,0,1…
- Protocol error:
  - Stimulus: second le on port1 while pending.
  - Required: latched addr unchanged; w_proto_err=1 and it stays 1; only one downstream transaction is issued.
- Store/odata isolation:
  - Stimulus: port1 load returns 0x5; then port1 store.
  - Required: odata[1] stays 0x5; no change to odata[0].
- Reset mid-WAIT:
  - Stimulus: assert RST_X=0 for one cycle during WAIT with port1 pending.
  - Required: next cycle is IDLE, no pending, no pulses, odata cleared; a new request completes normally.
